pixel_word_unpacker: RTL

PIXEL_WORD_UNPACKER -- requirements
Module: pixel_word_unpacker

---
 rtl/pixel_word_unpacker_pkg.sv | 22 ++
 rtl/pixel_word_buffer.sv | 88 ++++++++
 rtl/pixel_word_unpacker.sv | 118 +++++++++++
 3 files changed

// File: rtl/pixel_word_unpacker_pkg.sv
// Shared camera definitions: frame geometry defaults, derived word count and
// the unpacker FSM encoding.
package pixel_word_unpacker_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WORD_W_DEF   = 32;

    function automatic int words_per_frame(input int h, input int v, input int w);
        return (h * v) / w;
    endfunction

    // 9600 words for the default 640x480 frame at 32 pixels per word.
    localparam int WORDS_PER_FRAME_DEF = words_per_frame(H_ACTIVE_DEF, V_ACTIVE_DEF, WORD_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/pixel_word_buffer.sv
// Current-word shift register plus one prefetch word; hands out one bit per pop
// with no gap across word boundaries.
module pixel_word_buffer
    import pixel_word_unpacker_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int WORDS  = WORDS_PER_FRAME_DEF
) (
    input  logic              CLOCK_50,
    input  logic              DLY_RST_1,
    input  logic              flush,
    input  logic              enable,
    input  logic [WORD_W-1:0] word,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              pop,
    output logic              bit_out,
    output logic              bit_avail
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int WC_W  = $clog2(WORDS + 1);

    logic [WORD_W-1:0] cur, pre, eff_word, nxt_word;
    logic [CNT_W-1:0]  cur_cnt, eff_cnt, nxt_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              pre_full, pre_used, accept;

    // NOTE: every always_comb output gets a default on entry so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        eff_word = cur;
        eff_cnt  = cur_cnt;
        pre_used = 1'b0;
        // An empty shift register is served straight from prefetch, so a word
        // that landed last cycle is already visible to this cycle's request.
        if (cur_cnt == '0 && pre_full) begin
            eff_word = pre;
            eff_cnt  = CNT_W'(WORD_W);
            pre_used = 1'b1;
        end
        nxt_word = eff_word;
        nxt_cnt  = eff_cnt;
        if (pop && eff_cnt != '0) begin
            nxt_word = eff_word >> 1;
            nxt_cnt  = eff_cnt - CNT_W'(1);
            if (nxt_cnt == '0 && pre_full && !pre_used) begin
                nxt_word = pre;
                nxt_cnt  = CNT_W'(WORD_W);
                pre_used = 1'b1;
            end
        end
    end

    assign bit_avail  = (eff_cnt != '0);
    assign bit_out    = eff_word[0];
    assign word_ready = enable && !flush && !pre_full && (word_cnt < WC_W'(WORDS));
    assign accept     = word_valid && word_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            cur      <= '0;
            cur_cnt  <= '0;
            pre      <= '0;
            pre_full <= 1'b0;
            word_cnt <= '0;
        end else if (flush) begin
            cur      <= '0;
            cur_cnt  <= '0;
            pre      <= '0;
            pre_full <= 1'b0;
            word_cnt <= '0;
        end else begin
            cur     <= nxt_word;
            cur_cnt <= nxt_cnt;
            if (accept) begin
                pre      <= word;
                pre_full <= 1'b1;
                word_cnt <= word_cnt + WC_W'(1);
            end else if (pre_used) begin
                pre_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_word_unpacker.sv
// Unpacks 1-bit-per-pixel words into a raster pixel stream with position,
// frame markers, underrun flag and completed-frame count.
module pixel_word_unpacker
    import pixel_word_unpacker_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WORD_W   = WORD_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              DLY_RST_1,
    input  logic              iFRAME_START,
    input  logic [WORD_W-1:0] iWORD,
    input  logic              iWORD_VALID,
    output logic              oWORD_READY,
    input  logic              iPIX_REQ,
    output logic              oPIX,
    output logic              oPIX_VALID,
    output logic [9:0]        oX,
    output logic [8:0]        oY,
    output logic              oSOF,
    output logic              oEOF,
    output logic              oUNDERRUN,
    output logic [15:0]       oFRAME_CNT
);

    localparam int WORDS = words_per_frame(H_ACTIVE, V_ACTIVE, WORD_W);

    unpack_state_t state, state_nxt;
    logic [9:0]    pos_x;
    logic [8:0]    pos_y;
    logic          run, pop, flush, last_pos, first_pos, bit_out, bit_avail;

    assign run       = (state == ST_RUN);
    assign pop       = run && iPIX_REQ && !iFRAME_START;
    // A start pulse in DONE is dropped; the FSM always returns to IDLE first.
    assign flush     = iFRAME_START && (state != ST_DONE);
    assign first_pos = (pos_x == '0) && (pos_y == '0);
    assign last_pos  = (pos_x == 10'(H_ACTIVE - 1)) && (pos_y == 9'(V_ACTIVE - 1));

    pixel_word_buffer #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS)
    ) u_buffer (
        .CLOCK_50   (CLOCK_50),
        .DLY_RST_1  (DLY_RST_1),
        .flush      (flush),
        .enable     (run),
        .word       (iWORD),
        .word_valid (iWORD_VALID),
        .word_ready (oWORD_READY),
        .pop        (pop),
        .bit_out    (bit_out),
        .bit_avail  (bit_avail)
    );

    always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
        if (!DLY_RST_1) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (iFRAME_START) state_nxt = ST_RUN;
            ST_RUN:  if (pop && last_pos) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            pos_x      <= '0;
            pos_y      <= '0;
            oPIX       <= 1'b0;
            oPIX_VALID <= 1'b0;
            oX         <= '0;
            oY         <= '0;
            oSOF       <= 1'b0;
            oEOF       <= 1'b0;
            oUNDERRUN  <= 1'b0;
            oFRAME_CNT <= '0;
        end else begin
            oPIX       <= 1'b0;
            oPIX_VALID <= 1'b0;
            oSOF       <= 1'b0;
            oEOF       <= 1'b0;
            if (flush) begin
                pos_x     <= '0;
                pos_y     <= '0;
                oX        <= '0;
                oY        <= '0;
                oUNDERRUN <= 1'b0;
            end else if (pop) begin
                // A missing bit is dropped: the position advances regardless.
                oPIX       <= bit_avail & bit_out;
                oPIX_VALID <= bit_avail;
                oX         <= pos_x;
                oY         <= pos_y;
                oSOF       <= first_pos;
                oEOF       <= last_pos;
                if (!bit_avail) oUNDERRUN <= 1'b1;
                if (last_pos) begin
                    pos_x      <= '0;
                    pos_y      <= '0;
                    oFRAME_CNT <= oFRAME_CNT + 16'd1;
                end else if (pos_x == 10'(H_ACTIVE - 1)) begin
                    pos_x <= '0;
                    pos_y <= pos_y + 9'd1;
                end else begin
                    pos_x <= pos_x + 10'd1;
                end
            end
        end
    end

endmodule
